// File: rtl/cpu_top_level.sv
// rtl/cpu_top_level.sv - four-stage pipelined 32-bit CPU with unified memory; optional macro CPU_FORWARDING_EN
module cpu_top_level #(
    parameter int MEM_DEPTH = 2048,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cpu_en,
    input  logic [DATA_W-1:0]            w_instruction,
    input  logic                         w_enable,
    input  logic [$clog2(MEM_DEPTH)-1:0] w_adrs,
    output logic                         carry,
    output logic [DATA_W-1:0]            result
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_BRA   = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b111;

    // Operand field -> flat 6-bit register index {bank, reg}
    function automatic logic [5:0] reg_key(input logic [10:0] f);
        return f[10] ? {1'b1, f[9:5]} : {1'b0, f[4:0]};
    endfunction

    logic [DATA_W-1:0] mem    [MEM_DEPTH];
    logic [DATA_W-1:0] regs_q [64];

    logic [AW-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0] if_id_q;

    logic [2:0]        ex_op_q, ex_cond_q;
    logic [10:0]       ex_dst_q;
    logic [DATA_W-1:0] ex_a_q, ex_b_q;

    logic              wb_we_q, wb_arith_q, wb_carry_q;
    logic [5:0]        wb_key_q;
    logic [DATA_W-1:0] wb_val_q;

    logic [DATA_W-1:0] result_q;
    logic              carry_q, z_q;

    // ID decode
    logic [2:0]        id_op, id_cond;
    logic              id_imm;
    logic [10:0]       id_dst, id_src;
    logic [5:0]        id_dst_key, id_src_key;
    logic [DATA_W-1:0] id_a, id_b;

    assign id_op      = if_id_q[31:29];
    assign id_cond    = if_id_q[26:24];
    assign id_imm     = if_id_q[23];
    assign id_dst     = if_id_q[21:11];
    assign id_src     = if_id_q[10:0];
    assign id_dst_key = reg_key(id_dst);
    assign id_src_key = reg_key(id_src);

    // Reserved / ignored instruction bits
    logic unused_bits;
    assign unused_bits = ^{if_id_q[28:27], if_id_q[22]};

    // EX datapath
    logic [DATA_W:0]   ex_sum;
    logic              ex_arith, ex_load, ex_we, ex_store, ex_cond_ok, ex_take;
    logic [5:0]        ex_key;
    logic [DATA_W-1:0] ex_val;

    assign ex_arith = (ex_op_q == OP_ADD) || (ex_op_q == OP_SUB);
    assign ex_load  = (ex_op_q == OP_LOAD);
    assign ex_store = (ex_op_q == OP_STORE);
    assign ex_we    = ex_arith || ex_load;
    assign ex_key   = reg_key(ex_dst_q);
    assign ex_sum   = (ex_op_q == OP_SUB) ? ({1'b0, ex_a_q} - {1'b0, ex_b_q})
                                          : ({1'b0, ex_a_q} + {1'b0, ex_b_q});
    assign ex_val   = ex_load ? mem[ex_b_q[AW-1:0]] : ex_sum[DATA_W-1:0];
    assign ex_take  = (ex_op_q == OP_BRA) && ex_cond_ok;
    assign pc_d     = ex_take ? ex_dst_q[AW-1:0] : pc_q + 1'b1;

    // Branch condition against the flags of the last retired ADD/SUB
    always_comb begin
        ex_cond_ok = 1'b0;
        case (ex_cond_q)
            3'b000:  ex_cond_ok = 1'b1;
            3'b001:  ex_cond_ok = carry_q;
            3'b010:  ex_cond_ok = !carry_q;
            3'b011:  ex_cond_ok = z_q;
            3'b100:  ex_cond_ok = !z_q;
            default: ex_cond_ok = 1'b0;
        endcase
    end

    // ID operand read; optional bypass from EX (youngest) and WB
    always_comb begin
        id_a = regs_q[id_dst_key];
        id_b = id_imm ? {{(DATA_W-11){1'b0}}, id_src} : regs_q[id_src_key];
`ifdef CPU_FORWARDING_EN
        if (wb_we_q && wb_key_q == id_dst_key) id_a = wb_val_q;
        if (ex_we && ex_key == id_dst_key)     id_a = ex_val;
        if (!id_imm) begin
            if (wb_we_q && wb_key_q == id_src_key) id_b = wb_val_q;
            if (ex_we && ex_key == id_src_key)     id_b = ex_val;
        end
`endif
    end

    // Pipeline registers, PC and retired-arithmetic flags
    always_ff @(posedge clk) begin
        if (resetn) begin
            pc_q       <= '0;
            if_id_q    <= '0;
            ex_op_q    <= OP_NOP;
            ex_cond_q  <= '0;
            ex_dst_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_we_q    <= 1'b0;
            wb_arith_q <= 1'b0;
            wb_carry_q <= 1'b0;
            wb_key_q   <= '0;
            wb_val_q   <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            z_q        <= 1'b0;
        end else if (cpu_en) begin
            pc_q       <= pc_d;
            if_id_q    <= ex_take ? '0 : mem[pc_q];
            ex_op_q    <= ex_take ? OP_NOP : id_op;
            ex_cond_q  <= id_cond;
            ex_dst_q   <= id_dst;
            ex_a_q     <= id_a;
            ex_b_q     <= id_b;
            wb_we_q    <= ex_we;
            wb_arith_q <= ex_arith;
            wb_carry_q <= ex_sum[DATA_W];
            wb_key_q   <= ex_key;
            wb_val_q   <= ex_val;
            if (wb_arith_q) begin
                result_q <= wb_val_q;
                carry_q  <= wb_carry_q;
                z_q      <= (wb_val_q == '0);
            end
        end
    end

    // Register banks A/B, written at WB
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
        end else if (cpu_en && wb_we_q) begin
            regs_q[wb_key_q] <= wb_val_q;
        end
    end

    // Shared memory write port: host while halted, STORE while running
    always_ff @(posedge clk) begin
        if (!resetn) begin
            if (!cpu_en && w_enable)
                mem[w_adrs] <= w_instruction;
            else if (cpu_en && ex_store)
                mem[ex_b_q[AW-1:0]] <= ex_a_q;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
endmodule

// File: tb/tb_cpu_top_level.sv
// tb/tb_cpu_top_level.sv - directed self-checking bench for cpu_top_level
module tb_cpu_top_level;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cpu_en = 1'b0;
    logic [31:0] w_instruction = '0;
    logic        w_enable = 1'b0;
    logic [10:0] w_adrs = '0;
    logic        carry;
    logic [31:0] result;

    int checks = 0;
    int fails  = 0;

    localparam logic [2:0] NOP = 3'b000, SUB = 3'b011, ADD = 3'b100, BRA = 3'b101, LOAD = 3'b111;
    localparam logic [10:0] A0 = 11'd0, A1 = 11'd1, A2 = 11'd2, A3 = 11'd3, A4 = 11'd4;
    localparam logic [10:0] B3 = {1'b1, 5'd3, 5'd0};

    cpu_top_level dut (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en),
        .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs),
        .carry(carry), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] cond, input logic imm,
                                        input logic [10:0] dst, input logic [10:0] src);
        return {op, 2'b00, cond, imm, 1'b0, dst, src};
    endfunction

    task automatic tick(input int n);
        cpu_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        cpu_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [10:0] a, input logic [31:0] d);
        cpu_en = 1'b0;
        w_enable = 1'b1;
        w_adrs = a;
        w_instruction = d;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
    endtask

    task automatic fresh();
        cpu_en = 1'b0;
        do_reset();
        for (int i = 0; i < 256; i++) host_wr(11'(i), 32'd0);
    endtask

    task automatic load_prog1();
        host_wr(11'd100, 32'd10);
        host_wr(11'd101, 32'd11);
        host_wr(11'd1,  enc(LOAD, 3'd0, 1'b1, A3, 11'd100));
        host_wr(11'd2,  enc(LOAD, 3'd0, 1'b1, B3, 11'd101));
        host_wr(11'd5,  enc(ADD,  3'd0, 1'b1, A3, 11'd5));
        host_wr(11'd6,  enc(ADD,  3'd0, 1'b1, B3, 11'd1));
        host_wr(11'd9,  enc(SUB,  3'd0, 1'b1, A3, 11'd1));
        host_wr(11'd13, enc(ADD,  3'd0, 1'b0, A3, B3));
    endtask

    task automatic test_reset();
        fresh();
        checks++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got=%0h want=0", result); end
        checks++; if (carry !== 1'b0) begin fails++; $display("FAIL reset_carry got=%b want=0", carry); end
    endtask

    task automatic test_arith_seq();
        fresh();
        load_prog1();
        w_enable = 1'b1; w_adrs = 11'd13; w_instruction = enc(ADD, 3'd0, 1'b1, A3, 11'd100);
        tick(8);
        checks++; if (result !== 32'd0) begin fails++; $display("FAIL seq_e8 got=%0d want=0", result); end
        tick(1);
        checks++; if (result !== 32'd15) begin fails++; $display("FAIL seq_e9 got=%0d want=15", result); end
        tick(1);
        checks++; if (result !== 32'd12) begin fails++; $display("FAIL seq_e10 got=%0d want=12", result); end
        tick(3);
        checks++; if (result !== 32'd14) begin fails++; $display("FAIL seq_e13 got=%0d want=14", result); end
        tick(4);
        w_enable = 1'b0;
        checks++; if (result !== 32'd26) begin fails++; $display("FAIL seq_e17 got=%0d want=26", result); end
        checks++; if (carry !== 1'b0) begin fails++; $display("FAIL seq_carry got=%b want=0", carry); end
    endtask

    task automatic test_carry();
        fresh();
        host_wr(11'd200, 32'hFFFF_FFFF);
        host_wr(11'd0, enc(LOAD, 3'd0, 1'b1, A0, 11'd200));
        host_wr(11'd4, enc(ADD,  3'd0, 1'b1, A0, 11'd1));
        host_wr(11'd8, enc(SUB,  3'd0, 1'b1, A0, 11'd1));
        tick(7);
        checks++; if (carry !== 1'b0) begin fails++; $display("FAIL carry_pre got=%b want=0", carry); end
        tick(1);
        checks++; if (result !== 32'd0 || carry !== 1'b1) begin fails++; $display("FAIL add_wrap got=%0h/%b want=0/1", result, carry); end
        tick(4);
        checks++; if (result !== 32'hFFFF_FFFF || carry !== 1'b1) begin fails++; $display("FAIL sub_borrow got=%0h/%b want=ffffffff/1", result, carry); end
    endtask

    task automatic test_branch_loop();
        fresh();
        host_wr(11'd200, 32'd3);
        host_wr(11'd0, enc(LOAD, 3'd0, 1'b1, A1, 11'd200));
        host_wr(11'd4, enc(SUB,  3'd0, 1'b1, A1, 11'd1));
        host_wr(11'd7, enc(BRA,  3'b100, 1'b0, 11'd4, 11'd0));
        host_wr(11'd8, enc(ADD,  3'd0, 1'b1, A2, 11'd7));
        host_wr(11'd9, enc(ADD,  3'd0, 1'b1, A4, 11'd9));
        tick(8);
        checks++; if (result !== 32'd2) begin fails++; $display("FAIL loop_it0 got=%0d want=2", result); end
        tick(5);
        checks++; if (result !== 32'd2) begin fails++; $display("FAIL loop_squash got=%0d want=2", result); end
        tick(1);
        checks++; if (result !== 32'd1) begin fails++; $display("FAIL loop_it1 got=%0d want=1", result); end
        tick(6);
        checks++; if (result !== 32'd0 || carry !== 1'b0) begin fails++; $display("FAIL loop_it2 got=%0d/%b want=0/0", result, carry); end
        tick(4);
        checks++; if (result !== 32'd7) begin fails++; $display("FAIL loop_fall8 got=%0d want=7", result); end
        tick(1);
        checks++; if (result !== 32'd9) begin fails++; $display("FAIL loop_fall9 got=%0d want=9", result); end
    endtask

    task automatic test_freeze();
        fresh();
        load_prog1();
        tick(11);
        checks++; if (result !== 32'd12) begin fails++; $display("FAIL frz_pre got=%0d want=12", result); end
        hold(2);
        host_wr(11'd50, 32'd0);
        hold(2);
        checks++; if (result !== 32'd12 || carry !== 1'b0) begin fails++; $display("FAIL frz_hold got=%0d/%b want=12/0", result, carry); end
        tick(1);
        checks++; if (result !== 32'd12) begin fails++; $display("FAIL frz_e12 got=%0d want=12", result); end
        tick(1);
        checks++; if (result !== 32'd14) begin fails++; $display("FAIL frz_e13 got=%0d want=14", result); end
        tick(4);
        checks++; if (result !== 32'd26) begin fails++; $display("FAIL frz_e17 got=%0d want=26", result); end
    endtask

    task automatic test_mid_reset();
        fresh();
        load_prog1();
        tick(11);
        cpu_en = 1'b1;
        do_reset();
        checks++; if (result !== 32'd0 || carry !== 1'b0) begin fails++; $display("FAIL rst_mid got=%0d/%b want=0/0", result, carry); end
        tick(4);
        checks++; if (result !== 32'd0) begin fails++; $display("FAIL rst_flush got=%0d want=0", result); end
        tick(5);
        checks++; if (result !== 32'd15) begin fails++; $display("FAIL rst_e9 got=%0d want=15", result); end
        tick(1);
        checks++; if (result !== 32'd12) begin fails++; $display("FAIL rst_e10 got=%0d want=12", result); end
        tick(7);
        checks++; if (result !== 32'd26) begin fails++; $display("FAIL rst_e17 got=%0d want=26", result); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want2;
`ifdef CPU_FORWARDING_EN
        want2 = 32'd16;
`else
        want2 = 32'd11;
`endif
        fresh();
        host_wr(11'd100, 32'd10);
        host_wr(11'd0, enc(LOAD, 3'd0, 1'b1, A3, 11'd100));
        host_wr(11'd4, enc(ADD,  3'd0, 1'b1, A3, 11'd5));
        host_wr(11'd5, enc(ADD,  3'd0, 1'b1, A3, 11'd1));
        tick(8);
        checks++; if (result !== 32'd15) begin fails++; $display("FAIL b2b_first got=%0d want=15", result); end
        tick(1);
        checks++; if (result !== want2) begin fails++; $display("FAIL b2b_second got=%0d want=%0d", result, want2); end
    endtask

    initial begin
        test_reset();
        test_arith_seq();
        test_carry();
        test_branch_loop();
        test_freeze();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
